// File: rtl/jtframe_objdma_if.sv
// Bus and object-RAM signal bundle for jtframe_objdma.
// The master side belongs to the DMA engine. The slave side belongs to the arbiter and RAM.
interface jtframe_objdma_if #(
  parameter int AW  = 12,
  parameter int DW  = 8,
  parameter int OAW = 8
);
  logic           busrq;
  logic           busak_n;
  logic [AW-1:0]  bus_addr;
  logic           bus_rd;
  logic [DW-1:0]  bus_din;
  logic [OAW-1:0] dst_addr;
  logic [DW-1:0]  dst_dout;
  logic           dst_we;

  modport master (
    output busrq, bus_addr, bus_rd, dst_addr, dst_dout, dst_we,
    input  busak_n, bus_din
  );

  modport slave (
    input  busrq, bus_addr, bus_rd, dst_addr, dst_dout, dst_we,
    output busak_n, bus_din
  );
endinterface

// File: rtl/jtframe_objdma.sv
// Object-RAM DMA engine. It requests the CPU bus and copies LEN bytes from src_base into the object buffer.
// It can optionally hand the bus back to the CPU every BURST bytes.
module jtframe_objdma #(
  parameter int AW    = 12,
  parameter int DW    = 8,
  parameter int OAW   = 8,
  parameter int LEN   = 256,
  parameter int BURST = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          dma_go,
  input  logic [AW-1:0] src_base,
  jtframe_objdma_if.master bus,
  output logic          busy,
  output logic          done
);
  localparam int CW        = $clog2(LEN + 1);
  localparam bit USE_BURST = (BURST != 0) && (BURST < LEN);
  localparam int BW        = (BURST > 1) ? $clog2(BURST + 1) : 1;

  typedef enum logic [2:0] {IDLE, REQ, READ, WRITE, PAUSE, RELEASE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [BW-1:0] bcnt_q, bcnt_d, bcnt_inc;
  logic [AW-1:0] base_q, base_d;
  logic          go_q, go_d;
  logic          ack;

  assign ack = ~bus.busak_n;

  // go_q resets to 1 so that a dma_go already high when reset is released is not taken as an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      base_q  <= '0;
      go_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      base_q  <= base_d;
      go_q    <= go_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bcnt_d   = bcnt_q;
    base_d   = base_q;
    go_d     = cen ? dma_go : go_q;
    cnt_inc  = cnt_q + CW'(1);
    bcnt_inc = bcnt_q + BW'(1);
    case (state_q)
      IDLE: begin
        if (cen && dma_go && !go_q) begin
          base_d  = src_base;
          cnt_d   = '0;
          bcnt_d  = '0;
          state_d = REQ;
        end
      end
      REQ:   if (cen && ack) state_d = READ;
      READ:  if (cen && ack) state_d = WRITE;
      // If the bus is revoked during WRITE, the byte is not committed and is read again
      WRITE: begin
        if (cen) begin
          if (!ack) begin
            state_d = READ;
          end else begin
            cnt_d  = cnt_inc;
            bcnt_d = bcnt_inc;
            if (cnt_inc == CW'(LEN)) begin
              state_d = RELEASE;
            end else if (USE_BURST && (bcnt_inc == BW'(BURST))) begin
              bcnt_d  = '0;
              state_d = PAUSE;
            end else begin
              state_d = READ;
            end
          end
        end
      end
      PAUSE:   if (cen) state_d = REQ;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Source RAM registers the address on the READ cen and presents the byte during WRITE
  assign busy         = (state_q == REQ) || (state_q == READ) ||
                        (state_q == WRITE) || (state_q == PAUSE);
  assign bus.busrq    = (state_q == REQ) || (state_q == READ) || (state_q == WRITE);
  assign bus.bus_rd   = (state_q == READ) && ack;
  assign bus.bus_addr = (state_q == READ) ? (base_q + AW'(cnt_q)) : {AW{1'b0}};
  assign bus.dst_we   = (state_q == WRITE) && ack;
  assign bus.dst_addr = (state_q == WRITE) ? OAW'(cnt_q) : {OAW{1'b0}};
  assign bus.dst_dout = (state_q == WRITE) ? bus.bus_din : {DW{1'b0}};
  assign done         = (state_q == RELEASE);
endmodule

// File: tb/tb_jtframe_objdma.sv
// Scoreboard bench for jtframe_objdma. It drives four instances with different LEN/BURST settings.
// Each instance has its own source RAM and bus-grant model.
module tb_jtframe_objdma;
  function automatic int len_of(input int g);
    case (g)
      0: return 256;
      1: return 32;
      2: return 256;
      default: return 1;
    endcase
  endfunction

  function automatic int burst_of(input int g);
    return (g == 2) ? 64 : 0;
  endfunction

  function automatic int base_of(input int g);
    case (g)
      0: return 'h100;
      1: return 'hFF0;
      2: return 'h200;
      default: return 'h123;
    endcase
  endfunction

  typedef logic [15:0] q16_t[$];

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cen = 1'b0;
  logic [3:0] go;
  bit         gap_en;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  logic [3:0] we_v, rd_v, rq_v, busy_v, done_v, akn_v;
  logic [7:0] da_v [4];
  logic [7:0] dd_v [4];
  logic [11:0] ba_v [4];

  q16_t exp_q [4];
  int   we_cnt [4];
  int   done_cnt [4];
  int   pause_cnt [4];

  initial forever #5 clk = ~clk;

  // cen is deasserted on every fifth clock so that the hold behaviour is exercised
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cen = (cyc % 5) != 4;
      cyc++;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : gd
    jtframe_objdma_if #(.AW(12), .DW(8), .OAW(8)) ifc ();
    logic [7:0] mem_q = 8'h00;
    logic       akn;
    logic       busy_w, done_w;
    int         dly;
    int         gap_left;
    bit         gap_done;

    assign ifc.busak_n = akn;
    assign ifc.bus_din = mem_q;
    assign we_v[g]     = ifc.dst_we;
    assign rd_v[g]     = ifc.bus_rd;
    assign rq_v[g]     = ifc.busrq;
    assign busy_v[g]   = busy_w;
    assign done_v[g]   = done_w;
    assign akn_v[g]    = akn;
    assign da_v[g]     = ifc.dst_addr;
    assign dd_v[g]     = ifc.dst_dout;
    assign ba_v[g]     = ifc.bus_addr;

    jtframe_objdma #(
      .AW(12), .DW(8), .OAW(8), .LEN(len_of(g)), .BURST(burst_of(g))
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cen      (cen),
      .dma_go   (go[g]),
      .src_base (12'(base_of(g))),
      .bus      (ifc.master),
      .busy     (busy_w),
      .done     (done_w)
    );

    // The source RAM holds the low byte of each address
    always @(posedge clk) if (cen && ifc.bus_rd) mem_q <= ifc.bus_addr[7:0];

    // The bus is granted 3 clocks after busrq. On instance 0, a single 5-clock revoke is applied while byte 10 is being read.
    initial begin
      akn      = 1'b1;
      dly      = 0;
      gap_left = 0;
      gap_done = 1'b0;
      forever begin
        @(posedge clk);
        #1;
        if (!rst_n || !ifc.busrq) begin
          akn = 1'b1;
          dly = 0;
        end else if (gap_left > 0) begin
          gap_left--;
          if (gap_left == 0) akn = 1'b0;
        end else if (g == 0 && gap_en && !gap_done && ifc.bus_rd && we_cnt[0] == 10) begin
          akn      = 1'b1;
          gap_left = 5;
          gap_done = 1'b1;
        end else if (akn) begin
          dly++;
          if (dly >= 3) akn = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every committed write and checks the bus protocol
  initial begin
    forever begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        if (!rst_n) begin
          exp_q[g].delete();
          we_cnt[g]    = 0;
          done_cnt[g]  = 0;
          pause_cnt[g] = 0;
        end else begin
          if (we_v[g] || rd_v[g]) begin
            total++;
            if (akn_v[g]) begin
              bad++;
              $display("[TB] FAIL ack_gate dut%0d: we=%0b rd=%0b with busak_n=1, wanted both 0",
                       g, we_v[g], rd_v[g]);
            end
          end
          if (cen && rd_v[g]) begin
            logic [11:0] ea;
            ea = 12'(base_of(g) + we_cnt[g]);
            total++;
            if (ba_v[g] !== ea) begin
              bad++;
              $display("[TB] FAIL rd_addr dut%0d: got %03h, wanted %03h", g, ba_v[g], ea);
            end
          end
          if (cen && we_v[g]) begin
            total++;
            if (exp_q[g].size() == 0) begin
              bad++;
              $display("[TB] FAIL extra_write dut%0d: got addr %02h data %02h, wanted no write",
                       g, da_v[g], dd_v[g]);
            end else begin
              logic [15:0] e;
              e = exp_q[g].pop_front();
              if ({da_v[g], dd_v[g]} !== e) begin
                bad++;
                $display("[TB] FAIL write dut%0d #%0d: got addr %02h data %02h, wanted addr %02h data %02h",
                         g, we_cnt[g], da_v[g], dd_v[g], e[15:8], e[7:0]);
              end
            end
            we_cnt[g]++;
          end
          if (cen && busy_v[g] && !rq_v[g]) begin
            pause_cnt[g]++;
            total++;
            if (we_cnt[g] != burst_of(g) * pause_cnt[g]) begin
              bad++;
              $display("[TB] FAIL pause_point dut%0d: pause after %0d writes, wanted %0d",
                       g, we_cnt[g], burst_of(g) * pause_cnt[g]);
            end
          end
          if (done_v[g]) begin
            done_cnt[g]++;
            total++;
            if (rq_v[g] || busy_v[g]) begin
              bad++;
              $display("[TB] FAIL done_release dut%0d: busrq=%0b busy=%0b, wanted 0 0",
                       g, rq_v[g], busy_v[g]);
            end
          end
        end
      end
    end
  end

  task automatic check_output(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, wanted %0d", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input int g);
    for (int i = 0; i < len_of(g); i++) begin
      logic [11:0] a;
      logic [7:0]  ai;
      a  = 12'(base_of(g) + i);
      ai = 8'(i);
      exp_q[g].push_back({ai, a[7:0]});
    end
  endtask

  task automatic wait_done(input int g);
    int n;
    n = 0;
    while (done_cnt[g] == 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_output($sformatf("done_seen dut%0d", g), done_cnt[g] > 0 ? 1 : 0, 1);
  endtask

  task automatic wait_writes(input int g, input int target);
    int n;
    n = 0;
    while (we_cnt[g] < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_output($sformatf("reach_%0d dut%0d", target, g), we_cnt[g] >= target ? 1 : 0, 1);
  endtask

  task automatic apply_stimulus(input int g);
    int n;
    push_exp(g);
    go[g] = 1'b1;
    n = 0;
    while (!rq_v[g] && n < 4) begin
      @(negedge clk);
      n++;
    end
    check_output($sformatf("go_busrq dut%0d", g), int'(rq_v[g]), 1);
  endtask

  task automatic check_run(input int g, input int pauses);
    check_output($sformatf("writes dut%0d", g), we_cnt[g], len_of(g));
    check_output($sformatf("dones dut%0d", g), done_cnt[g], 1);
    check_output($sformatf("leftover dut%0d", g), exp_q[g].size(), 0);
    check_output($sformatf("pauses dut%0d", g), pause_cnt[g], pauses);
    check_output($sformatf("busrq_after dut%0d", g), int'(rq_v[g]), 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    go     = 4'hF;
    gap_en = 1'b0;
    tick(4);
    rst_n = 1'b1;
    tick(10);
    check_output("rst_busrq", int'(rq_v), 0);
    check_output("rst_busy", int'(busy_v), 0);
    check_output("rst_we", int'(we_v), 0);

    // Full copy with a bus revoke at byte 10 and an ignored second dma_go edge
    go = 4'h0;
    tick(3);
    gap_en = 1'b1;
    apply_stimulus(0);
    wait_writes(0, 100);
    tick(1);
    go[0] = 1'b0;
    tick(3);
    go[0] = 1'b1;
    wait_done(0);
    tick(20);
    check_run(0, 0);

    apply_stimulus(1);
    wait_done(1);
    tick(10);
    check_run(1, 0);

    apply_stimulus(2);
    wait_done(2);
    tick(10);
    check_run(2, 3);

    apply_stimulus(3);
    wait_done(3);
    tick(10);
    check_run(3, 0);

    // Asynchronous reset mid-transfer, then restart from byte 0
    go[0] = 1'b0;
    tick(3);
    apply_stimulus(0);
    wait_writes(0, 40);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_busrq", int'(rq_v[0]), 0);
    check_output("async_busy", int'(busy_v[0]), 0);
    check_output("async_we", int'(we_v[0]), 0);
    tick(3);
    rst_n = 1'b1;
    go[0] = 1'b0;
    tick(3);
    apply_stimulus(0);
    wait_done(0);
    tick(10);
    check_run(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/jtframe_objdma.md
Name: jtframe_objdma

Overview:
- Parametrised object-RAM DMA engine for jtframe cores. Successor to the fixed single-burst sprite DMA used by dma_go/busrq/busak_n in the Kunio-class game tops.
- Requests the main CPU bus, copies LEN bytes from CPU-visible RAM, starting at a programmable base, into the object buffer.
- Optionally releases the bus every BURST bytes so the CPU can run between bursts (cycle-steal mode).
- Sits between the main CPU bus arbiter and the video object RAM write port.

Parameters:
- AW, 12: source (CPU bus) address width.
- DW, 8: data width.
- OAW, 8: destination (object RAM) address width.
- LEN, 256: bytes per transfer; legal range 1..2**OAW.
- BURST, 0: bytes per bus tenure; 0 = hold the bus for the whole transfer.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cen  in  1  clock enable; all state advances only on cen=1 except done
- dma_go  in  1  start request, rising-edge detected on cen
- src_base  in  AW  source start address, sampled at start
- busrq  out  1  bus request to CPU, active high
- busak_n  in  1  bus acknowledge, active low
- bus_addr  out  AW  source read address
- bus_rd  out  1  source read strobe
- bus_din  in  DW  source read data, valid one cen after bus_addr/bus_rd
- dst_addr  out  OAW  object RAM write address
- dst_dout  out  DW  object RAM write data
- dst_we  out  1  object RAM write enable, one cen wide
- busy  out  1  transfer in progress
- done  out  1  one clk pulse at transfer end

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, counter 0, edge detector primed to 1 so a dma_go held high through reset does not start a transfer.
- Counter cnt width = clog2(LEN+1).
- IDLE:
  - On cen with dma_go=1 and previous sample 0: latch src_base to base, cnt=0, busy=1, busrq=1, go to REQ.
- REQ:
  - busrq=1. Wait for cen with busak_n=0, then go to READ.
- READ:
  - bus_addr=(base+cnt) truncated to AW bits (wraps), bus_rd=1.
  - If busak_n=1 on cen (bus revoked), stay in READ with bus_rd=0; no progress.
  - Otherwise go to WRITE on the next cen.
- WRITE:
  - Capture bus_din into dst_dout; dst_addr=cnt[OAW-1:0]; dst_we=1 for exactly this cen; cnt++.
  - If new cnt==LEN: go to RELEASE.
  - Else if BURST!=0 and new cnt mod BURST==0: go to PAUSE.
  - Else go to READ.
- PAUSE:
  - busrq=0 for one cen, then REQ.
- RELEASE:
  - busrq=0, bus_rd=0, busy=0, done=1 for one clk (not cen-qualified), then IDLE.
- Throughput: minimum 2 cen per byte. Byte N is written 2N+2 cen after the ack is first seen, counting from the REQ exit.
- dma_go edges while busy=1 are ignored; no queueing.
- busrq never drops mid-burst, except in PAUSE and RELEASE.
- dst_we and bus_rd are never high at the same time as busak_n=1.
- cen=0: all registered outputs hold; dst_we holds but is qualified by cen at the RAM.
- LEN=1: one READ/WRITE pair, then RELEASE.
- BURST>=LEN behaves as BURST=0.

Test Plan:
- Reset with dma_go=1 held, then release rst_n -> no busrq. Drop dma_go, raise it -> busrq=1 on the next cen.
- src_base=0x100, LEN=256, BURST=0, busak_n low 3 cen after busrq; source RAM holds address low byte -> 256 dst_we pulses, dst_addr 0..255 with data 0x00..0xFF, one done pulse, busrq low after the last write.
- src_base=0xFF0, AW=12, LEN=32 -> reads 0xFF0..0xFFF then 0x000..0x00F (wrap); dst_addr 0..31.
- BURST=64, LEN=256 -> busrq drops exactly 3 times for one cen each, after writes 64, 128 and 192; 256 writes total.
- Raise busak_n for 5 cen during byte 10 -> no bus_rd or dst_we during the gap; byte 10 is written correctly afterwards; total remains 256.
- Second dma_go edge mid-transfer -> ignored, single done. Assert rst_n=0 mid-transfer -> busrq, busy and dst_we drop immediately (asynchronously); next dma_go restarts from cnt=0.
